lut_neuron_layer_pipe: RTL

- Parametrised, runtime-loadable successor to the fixed-ROM LogicNets neuron.
- Holds NUM_NEURONS truth tables, each 2^ADDR_W entries of OUT_BITS, in distributed RAM.
- Tables are loaded over a sequential config stream, then input vectors are evaluated through a 1-stage registered pipeline with valid/ready handshakes.
- Sits between quantised-activation layers in the generated network.

---
 rtl/lut_neuron_layer_pipe.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/lut_neuron_layer_pipe.sv
// lut_neuron_layer_pipe: runtime-loadable LUT neuron layer.
// NUM_NEURONS truth tables of 2^ADDR_W x OUT_BITS are loaded over a sequential
// config stream, then evaluated through a 1-stage registered pipeline with
// valid/ready handshakes on both sides.
// Optional macro LUT_CFG_CHECKSUM_EN adds a rotate-xor checksum of loaded words.
module lut_neuron_layer_pipe #(
    parameter int unsigned NUM_NEURONS = 4,
    parameter int unsigned ADDR_W      = 6,
    parameter int unsigned OUT_BITS    = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cfg_start,
    input  logic                            cfg_valid,
    input  logic [OUT_BITS-1:0]             cfg_data,
    output logic                            cfg_ready,
    output logic                            cfg_done,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [NUM_NEURONS*ADDR_W-1:0]   in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_NEURONS*OUT_BITS-1:0] out_data,
    output logic                            loaded
`ifdef LUT_CFG_CHECKSUM_EN
    ,
    output logic [15:0]                     cfg_checksum
`endif
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned TOTAL = NUM_NEURONS * DEPTH;
    localparam int unsigned CNT_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

    typedef enum logic [1:0] {
        ST_UNLOADED,
        ST_LOAD,
        ST_RUN
    } state_t;

    state_t                          state_q, state_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic                            out_valid_q, out_valid_d;
    logic [NUM_NEURONS*OUT_BITS-1:0] out_data_q, out_data_d;
    logic                            cfg_done_q, cfg_done_d;

    logic [OUT_BITS-1:0]             mem [TOTAL];

    logic                            start_acc;
    logic                            wr_en;
    logic                            accept;
    logic [NUM_NEURONS*OUT_BITS-1:0] lookup;
    logic [CNT_W-1:0]                rd_idx;

    // Table storage: flattened neuron-major, written in load order, never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[cnt_q] <= cfg_data;
        end
    end

    // Parallel table lookup for every neuron.
    always_comb begin
        lookup = '0;
        rd_idx = '0;
        for (int unsigned n = 0; n < NUM_NEURONS; n++) begin
            rd_idx = CNT_W'(n * DEPTH) + CNT_W'(in_data[n*ADDR_W +: ADDR_W]);
            lookup[n*OUT_BITS +: OUT_BITS] = mem[rd_idx];
        end
    end

    // Handshakes, next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        cfg_done_d  = 1'b0;
        start_acc   = 1'b0;

        unique case (state_q)
            ST_UNLOADED, ST_LOAD: start_acc = cfg_start;
            ST_RUN:               start_acc = cfg_start & (!out_valid_q | out_ready);
            default:              start_acc = 1'b0;
        endcase

        cfg_ready = (state_q == ST_LOAD);
        loaded    = (state_q == ST_RUN);
        // An input offered alongside cfg_start would be discarded by the reload,
        // so refuse it rather than drop it silently.
        in_ready  = (state_q == ST_RUN) & (!out_valid_q | out_ready) & !cfg_start;
        accept    = in_valid & in_ready;
        wr_en     = (state_q == ST_LOAD) & cfg_valid & !cfg_start;

        if (start_acc) begin
            state_d     = ST_LOAD;
            cnt_d       = '0;
            out_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_LOAD: begin
                    if (wr_en) begin
                        if (cnt_q == LAST) begin
                            state_d    = ST_RUN;
                            cnt_d      = '0;
                            cfg_done_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        out_valid_d = 1'b1;
                        out_data_d  = lookup;
                    end else if (out_ready) begin
                        out_valid_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // State, counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_UNLOADED;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            cfg_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            cfg_done_q  <= cfg_done_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign cfg_done  = cfg_done_q;

`ifdef LUT_CFG_CHECKSUM_EN
    logic [15:0] chk_q, chk_d;

    // Rotate-left then xor each written word into the checksum.
    always_comb begin
        chk_d = chk_q;
        if (start_acc) begin
            chk_d = '0;
        end else if (wr_en) begin
            chk_d = {chk_q[14:0], chk_q[15]} ^ 16'(cfg_data);
        end
    end

    // Checksum register.
    always_ff @(posedge clk) begin
        if (rst) begin
            chk_q <= '0;
        end else begin
            chk_q <= chk_d;
        end
    end

    assign cfg_checksum = chk_q;
`else
    // Checksum disabled: no extra port or state.
`endif

endmodule
